// File: rtl/pe_pkg.sv
// pe_pkg: shared types for the peak_select block.
package pe_pkg;
    localparam int PEAKS_MAX = 8;
    localparam int BIN_W_MAX = 16;
    localparam int MAG_W_MAX = 32;
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
    typedef struct packed {
        logic [BIN_W_MAX-1:0] bin;
        logic [MAG_W_MAX-1:0] mag;
    } peak_t;
endpackage

// File: rtl/mag_approx.sv
// mag_approx: registered max + min/2 magnitude estimate of a signed complex sample.
module mag_approx #(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] re,
    input  logic signed [W-1:0] im,
    output logic        [W-1:0] mag
);
    logic [W-1:0] ar, ai, mx, mn;
    // Negating the most negative value wraps to 2^(W-1), which is exact when read unsigned.
    always_comb begin
        ar = re[W-1] ? -re : re;
        ai = im[W-1] ? -im : im;
        mx = ar > ai ? ar : ai;
        mn = ar > ai ? ai : ar;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) mag <= '0;
        else mag <= mx + (mn >> 1);
endmodule

// File: rtl/peak_select.sv
// peak_select: tracks the PEAKS strongest lower-half bins of an FFT frame
// and streams them out strongest first after end of frame.
module peak_select import pe_pkg::*; #(
    parameter int I_WIDTH = 14,
    parameter int FFT     = 11,
    parameter int PEAKS   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic                      sink_valid,
    input  logic signed [I_WIDTH-1:0] sink_real,
    input  logic signed [I_WIDTH-1:0] sink_imag,
    output logic                      sink_ready,
    output logic                      source_sop,
    output logic                      source_eop,
    output logic                      source_valid,
    output logic [FFT-1:0]            source_bin,
    output logic [I_WIDTH-1:0]        source_mag,
    output logic                      frame_err
);
    localparam int RW = PEAKS > 1 ? $clog2(PEAKS) : 1;
    localparam logic [FFT-1:0] LAST_BIN = '1;
    state_t state, state_n;
    peak_t tbl [PEAKS];
    peak_t tbl_n [PEAKS];
    peak_t cand;
    logic [PEAKS-1:0] gt;
    logic [FFT-1:0] bin_cnt, beat_bin, s1_bin;
    logic [I_WIDTH-1:0] s1_mag;
    logic [RW-1:0] rank;
    logic rdy, acc, drain, frame, clr, last, s1_cand, s1_eop, s2_eop;

    mag_approx #(.W(I_WIDTH)) u_mag (
        .clk(clk), .reset(reset), .re(sink_real), .im(sink_imag), .mag(s1_mag)
    );

    assign acc = sink_valid && sink_ready;
    // Beats arriving while the eop result drains through the pipeline are not part of any frame.
    assign drain = s1_eop || s2_eop;
    assign frame = acc && (state == IDLE ? sink_sop : state == COLLECT && !drain);
    assign clr = frame && sink_sop;
    assign beat_bin = sink_sop ? '0 : bin_cnt;
    assign last = rank == RW'(PEAKS - 1);
    assign sink_ready = rdy && state != EMIT;
    assign source_valid = state == EMIT;
    assign source_sop = source_valid && rank == '0;
    assign source_eop = source_valid && last;
    assign source_bin = source_valid ? tbl[rank].bin[FFT-1:0] : '0;
    assign source_mag = source_valid ? tbl[rank].mag[I_WIDTH-1:0] : '0;

    // gt is a run of zeros then ones, so the first set bit is the insertion slot.
    always_comb begin
        cand = '{bin: BIN_W_MAX'(s1_bin), mag: MAG_W_MAX'(s1_mag)};
        for (int k = 0; k < PEAKS; k++) gt[k] = MAG_W_MAX'(s1_mag) > tbl[k].mag;
        tbl_n[0] = gt[0] ? cand : tbl[0];
        for (int k = 1; k < PEAKS; k++) tbl_n[k] = gt[k-1] ? tbl[k-1] : gt[k] ? cand : tbl[k];
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (clr ? COLLECT : IDLE) :
                  state == COLLECT ? (s2_eop ? EMIT : COLLECT) :
                  (last ? IDLE : EMIT);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rdy <= 1'b0;
            bin_cnt <= '0;
            s1_bin <= '0;
            s1_cand <= 1'b0;
            s1_eop <= 1'b0;
            s2_eop <= 1'b0;
            rank <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < PEAKS; k++) tbl[k] <= '0;
        end else begin
            rdy <= 1'b1;
            s1_bin <= beat_bin;
            s1_cand <= frame && beat_bin != '0 && !beat_bin[FFT-1];
            s1_eop <= frame && sink_eop;
            s2_eop <= s1_eop;
            rank <= state == EMIT && !last ? rank + RW'(1) : '0;
            frame_err <= (acc && state == IDLE && sink_eop && !sink_sop) ||
                         (frame && ((sink_eop && beat_bin != LAST_BIN) || (state == COLLECT && sink_sop)));
            if (frame) bin_cnt <= beat_bin + FFT'(1);
            for (int k = 0; k < PEAKS; k++) tbl[k] <= clr ? '0 : s1_cand ? tbl_n[k] : tbl[k];
        end
endmodule

// File: tb/tb_peak_select.sv
// tb_peak_select: directed checks of peak_select with FFT=4, PEAKS=3, I_WIDTH=14.
module tb_peak_select;
    localparam int W = 14, F = 4, P = 3;
    logic clk = 0, reset = 1, sink_sop = 0, sink_eop = 0, sink_valid = 0;
    logic signed [W-1:0] sink_real = '0, sink_imag = '0;
    logic sink_ready, source_sop, source_eop, source_valid, frame_err;
    logic [F-1:0] source_bin;
    logic [W-1:0] source_mag;
    int errors = 0, checks = 0;
    int vr[16], vi[16];
    int rb[3], rm[3];
    logic rs[3], reo[3], rv[3], rr[3];
    int lat;
    logic pv;

    peak_select #(.I_WIDTH(W), .FFT(F), .PEAKS(P)) dut (
        .clk(clk), .reset(reset), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_valid(sink_valid), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_ready(sink_ready), .source_sop(source_sop), .source_eop(source_eop),
        .source_valid(source_valid), .source_bin(source_bin), .source_mag(source_mag),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic s, input logic e, input int r, input int i);
        sink_valid = 1; sink_sop = s; sink_eop = e; sink_real = W'(r); sink_imag = W'(i);
        @(posedge clk); #1;
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
    endtask

    task automatic clear_vec();
        for (int k = 0; k < 16; k++) begin vr[k] = 0; vi[k] = 0; end
    endtask

    task automatic send_frame(input int n);
        for (int k = 0; k < n; k++) beat(k == 0, k == n - 1, vr[k], vi[k]);
    endtask

    // Called one cycle after the eop beat; lat counts further cycles until first valid.
    task automatic get_emit();
        lat = 0;
        while (!source_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        for (int k = 0; k < 3; k++) begin
            rb[k] = int'(source_bin); rm[k] = int'(source_mag);
            rs[k] = source_sop; reo[k] = source_eop; rv[k] = source_valid; rr[k] = sink_ready;
            @(posedge clk); #1;
        end
        pv = source_valid;
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #10;
        checks++;
        if ({source_valid, source_sop, source_eop, source_bin, source_mag, frame_err, sink_ready} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {source_valid, source_sop, source_eop, source_bin, source_mag, frame_err, sink_ready});
        end
        @(negedge clk); reset = 1; #1;
        checks++;
        if (sink_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", sink_ready); end
        @(posedge clk); #1;
        checks++;
        if (sink_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", sink_ready); end
    endtask

    task automatic test_basic();
        int eb[3] = '{5, 6, 3};
        int em[3] = '{300, 200, 100};
        clear_vec();
        vr[3] = 100; vr[5] = 300; vr[6] = 200; vr[2] = 50;
        send_frame(16);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_no_err: got %b want 0", frame_err); end
        get_emit();
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== eb[k] || rm[k] !== em[k] || rv[k] !== 1'b1 || rs[k] !== (k == 0) || reo[k] !== (k == 2)) begin
                errors++; $display("FAIL basic_beat%0d: got bin=%0d mag=%0d v=%b sop=%b eop=%b want bin=%0d mag=%0d v=1 sop=%b eop=%b",
                                   k, rb[k], rm[k], rv[k], rs[k], reo[k], eb[k], em[k], k == 0, k == 2);
            end
        end
        checks++;
        if (pv !== 1'b0) begin errors++; $display("FAIL basic_end: valid got %b want 0", pv); end
    endtask

    task automatic test_tie_range();
        int eb[3] = '{2, 4, 5};
        int em[3] = '{80, 80, 55};
        clear_vec();
        vr[0] = 8191; vr[9] = 8191; vr[2] = 80; vr[4] = 80; vr[5] = -30; vi[5] = 40;
        send_frame(16);
        get_emit();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== eb[k] || rm[k] !== em[k]) begin
                errors++; $display("FAIL tie_beat%0d: got bin=%0d mag=%0d want bin=%0d mag=%0d", k, rb[k], rm[k], eb[k], em[k]);
            end
        end
    endtask

    task automatic test_min_neg();
        int eb[3] = '{1, 3, 0};
        int em[3] = '{12288, 1, 0};
        clear_vec();
        vr[1] = -8192; vi[1] = -8192; vi[3] = -1;
        send_frame(16);
        get_emit();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== eb[k] || rm[k] !== em[k]) begin
                errors++; $display("FAIL minneg_beat%0d: got bin=%0d mag=%0d want bin=%0d mag=%0d", k, rb[k], rm[k], eb[k], em[k]);
            end
        end
    endtask

    task automatic test_restart();
        int eb[3] = '{2, 6, 0};
        int em[3] = '{40, 20, 0};
        for (int k = 0; k < 7; k++) begin
            beat(k == 0, 0, k == 3 ? 500 : k == 6 ? 600 : 0, 0);
            if (k == 1) begin
                checks++;
                if (frame_err !== 1'b0) begin errors++; $display("FAIL restart_clean_beat: got %b want 0", frame_err); end
            end
        end
        beat(1, 0, 0, 0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL restart_err: got %b want 1", frame_err); end
        for (int k = 1; k < 16; k++) beat(0, k == 15, k == 2 ? 40 : k == 6 ? 20 : 0, 0);
        get_emit();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== eb[k] || rm[k] !== em[k]) begin
                errors++; $display("FAIL restart_beat%0d: got bin=%0d mag=%0d want bin=%0d mag=%0d", k, rb[k], rm[k], eb[k], em[k]);
            end
        end
    endtask

    task automatic test_eop_err();
        int eb[3] = '{4, 1, 0};
        int em[3] = '{70, 10, 0};
        clear_vec();
        vr[1] = 10; vr[4] = 70; vr[8] = 999;
        send_frame(11);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL short_eop_err: got %b want 1", frame_err); end
        sink_valid = 1; sink_sop = 1; sink_real = 5000;
        get_emit();
        sink_valid = 0; sink_sop = 0; sink_real = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== eb[k] || rm[k] !== em[k] || rv[k] !== 1'b1 || rr[k] !== 1'b0) begin
                errors++; $display("FAIL short_beat%0d: got bin=%0d mag=%0d v=%b rdy=%b want bin=%0d mag=%0d v=1 rdy=0",
                                   k, rb[k], rm[k], rv[k], rr[k], eb[k], em[k]);
            end
        end
        checks++;
        if (pv !== 1'b0) begin errors++; $display("FAIL short_end: valid got %b want 0", pv); end
    endtask

    task automatic test_sop_eop();
        beat(1, 1, 1000, 0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL onebin_err: got %b want 1", frame_err); end
        get_emit();
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL onebin_latency: got %0d want 2", lat); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rb[k] !== 0 || rm[k] !== 0 || rv[k] !== 1'b1) begin
                errors++; $display("FAIL onebin_beat%0d: got bin=%0d mag=%0d v=%b want bin=0 mag=0 v=1", k, rb[k], rm[k], rv[k]);
            end
        end
    endtask

    task automatic test_idle_eop();
        int seen = 0;
        beat(0, 1, 0, 0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL idle_eop_err: got %b want 1", frame_err); end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL idle_eop_pulse: got %b want 0", frame_err); end
        for (int k = 0; k < 6; k++) begin seen += int'(source_valid); @(posedge clk); #1; end
        checks++;
        if (seen !== 0 || sink_ready !== 1'b1) begin
            errors++; $display("FAIL idle_eop_ignored: got valids=%0d rdy=%b want valids=0 rdy=1", seen, sink_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        int n = 0, seen = 0;
        clear_vec();
        vr[3] = 100; vr[5] = 300; vr[6] = 200; vr[2] = 50;
        send_frame(16);
        while (!source_valid && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        checks++;
        if (source_valid !== 1'b1 || source_bin !== 4'd6) begin
            errors++; $display("FAIL mid_second_beat: got v=%b bin=%0d want v=1 bin=6", source_valid, source_bin);
        end
        reset = 0; #1;
        checks++;
        if ({source_valid, source_sop, source_eop, source_bin, source_mag, frame_err, sink_ready} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0", {source_valid, source_sop, source_eop, source_bin, source_mag, frame_err, sink_ready});
        end
        @(posedge clk); @(negedge clk); reset = 1;
        @(posedge clk); #1;
        checks++;
        if (sink_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b want 1", sink_ready); end
        for (int k = 0; k < 8; k++) begin seen += int'(source_valid); @(posedge clk); #1; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d valid beats want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_range();
        test_min_neg();
        test_restart();
        test_eop_err();
        test_sop_eop();
        test_idle_eop();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/peak_select.md
PEAK_SELECT -- requirements
Module: peak_select

Interface
REQ-001 Parameter I_WIDTH, default 14, signed width of the real and imaginary FFT input samples.
REQ-002 Parameter FFT, default 11, log2 of the frame length in bins.
REQ-003 Parameter PEAKS, default 4, number of strongest bins reported per frame (1..8).
REQ-004 clk  in  1  the single clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 sink_sop / sink_eop / sink_valid  in  1 each  frame delimiters and beat qualifier.
REQ-007 sink_real, sink_imag  in  I_WIDTH each  signed bin value.
REQ-008 sink_ready  out  1  high when a beat is accepted.
REQ-009 source_sop / source_eop / source_valid  out  1 each  result-stream framing.
REQ-010 source_bin  out  FFT  bin index of the reported peak.
REQ-011 source_mag  out  I_WIDTH  unsigned magnitude of the reported peak.
REQ-012 frame_err  out  1  one-cycle pulse on a malformed frame.

Function
REQ-013 A beat is accepted iff sink_valid && sink_ready; unaccepted beats are discarded.
REQ-014 FSM states are IDLE, COLLECT and EMIT; reset enters IDLE.
REQ-015 IDLE->COLLECT on an accepted beat with sink_sop; that beat is bin 0; the bin counter clears and the peak table fills with (bin 0, mag 0).
REQ-016 COLLECT: the bin counter increments per accepted beat and wraps modulo 2^FFT.
REQ-017 Magnitude = max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned I_WIDTH bits; |-2^(I_WIDTH-1)| is exact with no saturation.
REQ-018 The magnitude is registered one cycle after acceptance, and table insertion occurs the following cycle.
REQ-019 Only bins 1..2^(FFT-1)-1 are candidates; DC and the upper half are ignored.
REQ-020 The table holds PEAKS entries sorted by descending magnitude; a candidate strictly larger than entry i inserts at the lowest such i, and lower entries shift down, dropping the last.
REQ-021 On equal magnitude the earlier bin keeps the higher rank.
REQ-022 An accepted beat with sink_sop while in COLLECT restarts the frame (table cleared, counter reset to bin 0) and pulses frame_err.
REQ-023 An accepted sink_eop moves COLLECT->EMIT once the pipeline drains, 2 cycles after the eop beat.
REQ-024 If the eop beat's bin index is not 2^FFT-1, frame_err pulses and emission still occurs.
REQ-025 An eop without a preceding sop (in IDLE) is ignored and pulses frame_err.
REQ-026 EMIT outputs PEAKS consecutive beats with source_valid high, rank 0 first; source_sop is on the first beat, source_eop on the last (both on one beat when PEAKS=1).
REQ-027 The first emitted beat appears 3 cycles after the accepted eop beat.
REQ-028 sink_ready is low in EMIT and high in IDLE and COLLECT; EMIT->IDLE follows the last beat.
REQ-029 sink_sop and sink_eop on the same beat form a one-bin frame: bin 0 only, all-zero table emitted, frame_err pulses.

Reset
REQ-030 While reset is low, all source_* outputs and frame_err are 0, sink_ready is 0, the table is cleared and the FSM is in IDLE.
REQ-031 Reset asserted mid-COLLECT or mid-EMIT aborts immediately; no partial emission resumes after release.
REQ-032 sink_ready rises on the first clk edge after reset deasserts.

Structure
REQ-033 A shared package pe_pkg holds the state enum type, the peak entry struct {bin, mag}, and the PEAKS upper bound constant.
REQ-034 The magnitude approximation is a separate sub-module, mag_approx (registered, 1-cycle latency).

Verification (FFT=4, PEAKS=3, I_WIDTH=14)
REQ-035 16-bin frame with mag 100@bin3, 300@bin5, 200@bin6, 50@bin2, rest 0 -> emit (5,300), (6,200), (3,100), with sop on beat 1, eop on beat 3, and first valid 3 cycles after eop.
REQ-036 Bins 2 and 4 both at re=80, im=0 -> bin 2 ranks above bin 4; bin 0 with re=8191 and bin 9 with re=8191 are never reported.
REQ-037 re=-8192, im=-8192 at bin 1 -> source_mag 12288.
REQ-038 Second sop at bin 7 -> frame_err pulse; only bins after the restart appear in the output.
REQ-039 eop at bin 10 -> frame_err pulse and 3 beats emitted; sink_valid held high during EMIT -> those beats dropped and sink_ready is 0.
REQ-040 Reset asserted during the second EMIT beat -> outputs 0 next cycle and no further source_valid until a new frame arrives.
